// File: rtl/packer_master_if.sv
// Packer handshake bundle: operand beat in, packed IEEE result out.
// Modport master is the packer's side of the bus.
interface packer_master_if #(
  parameter int EW = 13,
  parameter int FW = 56
);
  logic          in_valid;
  logic          in_ready;
  logic          db;
  logic [1:0]    rm;
  logic          s;
  logic [EW-1:0] e;
  logic [FW-1:0] f;
  logic [3:0]    fl;
  logic [51:0]   nan;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   fp;
  logic [3:0]    exc;

  modport master (
    input  in_valid, db, rm, s, e, f,
    input  fl, nan, out_ready,
    output in_ready, out_valid, fp, exc
  );

  modport slave (
    output in_valid, db, rm, s, e, f,
    output fl, nan, out_ready,
    input  in_ready, out_valid, fp, exc
  );
endinterface

// File: rtl/packer_master.sv
// IEEE-754 result packer: rounding, renormalization, saturation,
// flush-to-zero and NaN quieting over a 2-stage valid/ready pipe.
module packer_master #(
  parameter int EW = 13,
  parameter int FW = 56
) (
  input logic            clk,
  input logic            reset,
  packer_master_if.master bus
);

  typedef enum logic [2:0] {
    CL_NORM,
    CL_ZERO,
    CL_INF,
    CL_QNAN,
    CL_SNAN
  } cls_t;

  typedef struct packed {
    logic          db;
    logic [1:0]    rm;
    logic          s;
    logic [EW-1:0] e;
    logic [52:0]   man;
    logic          inc;
    logic          inx;
    cls_t          cls;
    logic [51:0]   qf;
  } s1_t;

  function automatic logic [63:0] pack(
    input logic        dbl,
    input logic        sg,
    input logic [10:0] ex,
    input logic [51:0] fr
  );
    logic [31:0] h;
    h = {sg, ex[7:0], fr[22:0]};
    return dbl ? {sg, ex, fr} : {h, h};
  endfunction

  s1_t  nx;
  s1_t  s1;
  logic s1_valid;
  logic s2_valid;
  logic s2_load;
  logic in_ready;
  logic lsb;
  logic g;
  logic st;

  logic [63:0] fp_q;
  logic [3:0]  exc_q;

  assign s2_load  = !s2_valid || bus.out_ready;
  assign in_ready = !s1_valid || s2_load;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.fp        = fp_q;
  assign bus.exc       = exc_q;

  always_comb begin
    nx     = '0;
    lsb    = 1'b0;
    g      = 1'b0;
    st     = 1'b0;
    nx.db  = bus.db;
    nx.rm  = bus.rm;
    nx.s   = bus.s;
    nx.e   = bus.e;
    if (bus.db) begin
      nx.man = bus.f[55:3];
      lsb    = bus.f[3];
      g      = bus.f[2];
      st     = |bus.f[1:0];
      nx.qf  = {1'b1, bus.nan[51:1]};
    end else begin
      nx.man = {29'd0, bus.f[55:32]};
      lsb    = bus.f[32];
      g      = bus.f[31];
      st     = |bus.f[30:0];
      nx.qf  = {29'd0, 1'b1, bus.nan[51:30]};
    end
    case (bus.rm)
      2'b00:   nx.inc = g & (lsb | st);
      2'b01:   nx.inc = 1'b0;
      2'b10:   nx.inc = !bus.s & (g | st);
      default: nx.inc = bus.s & (g | st);
    endcase
    nx.inx = g | st;
    if (bus.fl[0])      nx.cls = CL_SNAN;
    else if (bus.fl[1]) nx.cls = CL_QNAN;
    else if (bus.fl[2]) nx.cls = CL_INF;
    else if (bus.fl[3]) nx.cls = CL_ZERO;
    else                nx.cls = CL_NORM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1 <= nx;
    end
  end

  logic [53:0]        sum;
  logic               carry;
  logic [51:0]        frac;
  logic signed [EW:0] ex;
  logic signed [EW:0] ep;
  logic signed [EW:0] emax;
  logic               ovf;
  logic               unf;
  logic               to_inf;
  logic [10:0]        e_max;
  logic [63:0]        r;
  logic [3:0]         x;

  always_comb begin
    sum   = {1'b0, s1.man} + {53'd0, s1.inc};
    carry = s1.db ? sum[53] : sum[24];
    frac  = s1.db ? sum[51:0] : {29'd0, sum[22:0]};
    if (carry) frac = '0;
    ex    = {s1.e[EW-1], s1.e};
    ep    = carry ? ex + (EW+1)'(1) : ex;
    emax  = s1.db ? (EW+1)'(2046) : (EW+1)'(254);
    e_max = s1.db ? 11'h7FE : 11'h0FE;
    // out-of-range exponents are judged at full width, never wrapped
    ovf   = ep > emax;
    unf   = ep[EW] || (ep == '0) || ex[EW] || (ex == '0);
    to_inf = (s1.rm == 2'b00)
          || (s1.rm == 2'b10 && !s1.s)
          || (s1.rm == 2'b11 && s1.s);
    r = '0;
    x = '0;
    unique case (s1.cls)
      CL_SNAN: begin
        r = pack(s1.db, s1.s, 11'h7FF, s1.qf);
        x = 4'b1000;
      end
      CL_QNAN: r = pack(s1.db, s1.s, 11'h7FF, s1.qf);
      CL_INF:  r = pack(s1.db, s1.s, 11'h7FF, '0);
      CL_ZERO: r = pack(s1.db, s1.s, '0, '0);
      default: begin
        if (ovf) begin
          x = 4'b0101;
          if (to_inf) r = pack(s1.db, s1.s, 11'h7FF, '0);
          else        r = pack(s1.db, s1.s, e_max, '1);
        end else if (unf) begin
          x = 4'b0011;
          r = pack(s1.db, s1.s, '0, '0);
        end else begin
          x = {3'b000, s1.inx};
          r = pack(s1.db, s1.s, ep[10:0], frac);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      fp_q     <= '0;
      exc_q    <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        fp_q  <= r;
        exc_q <= x;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.nan[0], sum[52]};

endmodule

// File: doc/packer_master.md
Name: packer_master

Overview:
- Inverse of the operand unpacker: takes an internal sign/exponent/significand result with special-value flags and packs it into an IEEE-754 word, double or single.
- Performs rounding (4 modes), post-round renormalization, overflow saturation, flush-to-zero underflow and NaN quieting.
- Sits at the FPU result end: arithmetic core -> packer_master -> result bus.
- 2-stage valid/ready pipeline with full stall support.

Parameters:
- EW, 13: width of the signed biased exponent input (two's complement, so out-of-range values are representable).
- FW, 56: significand input width; must stay 56.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  packer can accept a beat.
- db  in  1  1 = double, 0 = single.
- rm  in  2  rounding mode: 00 RNE, 01 RZ, 10 RUP (+inf), 11 RDN (-inf).
- s  in  1  sign.
- e  in  EW  signed biased exponent (bias 1023 for double, 127 for single).
- f  in  FW  significand.
  - Double: f[55] hidden bit, f[54:3] fraction, f[2] guard, sticky = |f[1:0].
  - Single: f[55] hidden bit, f[54:32] fraction, f[31] guard, sticky = |f[30:0].
- fl  in  4  {zero, inf, qnan, snan}.
- nan  in  52  NaN payload, left-aligned.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- fp  out  64  packed result. Single results are replicated into both halves: {r32, r32}.
- exc  out  4  {inv, ov, un, inx}.

Behaviour:
- Reset (synchronous, active-high): both stage valids cleared; out_valid=0; fp=0; exc=0; in_ready=1 in the cycle after reset. Reset mid-operation discards all in-flight beats, and no output beat is produced from them.
- Handshake:
  - A beat transfers when valid && ready.
  - Stage advance rule: stage 2 loads when it is empty or out_ready=1.
  - in_ready = !s1_valid || stage 2 loads.
  - Throughput is 1 beat/cycle when out_ready=1.
  - Latency: a beat accepted in cycle N has out_valid=1 in cycle N+2.
  - While out_valid=1 && out_ready=0, fp and exc hold stable.
  - Capacity is 2 beats; order is preserved.
- Stage 1 (registered at acceptance):
  - Select format fields.
  - Compute lsb, guard and sticky.
  - Compute increment:
    - RNE: g & (lsb | st).
    - RZ: 0.
    - RUP: !s & (g | st).
    - RDN: s & (g | st).
  - inx_pre = g | st.
  - Register the special-case class by priority: snan > qnan > inf > zero > normal.
- Stage 2 (combinational from the stage 1 registers, registered into fp/exc):
  - Add the increment to {hidden, fraction}.
  - Carry out of the hidden bit: e' = e+1, fraction = 0.
  - emax = 2046 for double, 254 for single.
- Normal class:
  - e' > emax (overflow): ov=1, inx=1.
    - Result is ±inf when RNE, when RUP with s=0, or when RDN with s=1.
    - Otherwise the result is the largest finite value with sign s.
  - e' <= 0, or e <= 0 before rounding (underflow): flush to signed zero with un=1, inx=1.
  - Otherwise: fp = {s, e'[field], fraction}, inx = inx_pre.
- Special classes (the increment is ignored; ov, un and inx are 0):
  - zero: {s, 0}.
  - inf: {s, all-ones exponent, 0}.
  - qnan: {s, all-ones exponent, 1, nan[51:1]} for double. For single, the fraction is {1, nan[51:30]}.
  - snan: same encoding as qnan (quieted) with inv=1.
- Simultaneous events:
  - Accept in the same cycle as output consume is allowed.
  - Reset dominates valid.
- Field truncation only occurs after range checks; e is never wrapped.

Test Plan:
- Double 3.0: s=0, e=1024, f[55]=1, f[54]=1, others 0, rm=RNE -> fp=0x4008000000000000, exc=0, out_valid 2 cycles after acceptance.
- Single 100.0: db=0, e=133, f[55:32]=0xC80000 -> fp=0x42C8000042C80000, exc=0.
- Round carry: double, e=1023, f[55:3] all ones, g=1, RNE -> fp=0x4000000000000000, inx=1. The same input with RZ -> fp=0x3FFFFFFFFFFFFFFF, inx=1.
- Overflow: double, e=2047, normal class:
  - RNE -> 0x7FF0000000000000, ov=1, inx=1.
  - RZ -> 0x7FEFFFFFFFFFFFFF.
  - Underflow case: e=0 with s=1 -> 0x8000000000000000, un=1, inx=1.
- Specials: snan with nan=0x0000000000001 (double) -> 0x7FF8000000000000, inv=1. fl=zero with s=1 -> 0x8000000000000000.
- Backpressure and reset:
  - Hold out_ready=0 and send 3 beats: in_ready drops after 2 accepted and fp holds beat 1. Release out_ready: beats emerge in order with no loss or duplication.
  - Assert reset with 2 beats in flight: out_valid=0 the next cycle, and no stale beat appears afterwards.
